// File: rtl/regfile_mp_scoreboard_if.sv
// Decode/writeback-facing bundle of the multi-port register file with busy scoreboard.
// Master drives write, clear, read and issue requests; slave returns read data and status.
interface regfile_mp_scoreboard_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NR_READ    = 2,
  parameter int unsigned NR_WRITE   = 2
);
  logic [NR_WRITE-1:0]            wen;
  logic [NR_WRITE*ADDR_WIDTH-1:0] waddr;
  logic [NR_WRITE*DATA_WIDTH-1:0] wdata;
  logic [NR_WRITE-1:0]            wclr;
  logic [NR_READ*ADDR_WIDTH-1:0]  raddr;
  logic [NR_READ*DATA_WIDTH-1:0]  rdata;
  logic [NR_READ-1:0]             rbusy;
  logic                           issue_valid;
  logic [ADDR_WIDTH-1:0]          issue_rd;
  logic                           any_busy;
  logic [DATA_WIDTH-1:0]          a0_value;

  modport master (
    output wen, waddr, wdata, wclr, raddr, issue_valid, issue_rd,
    input  rdata, rbusy, any_busy, a0_value
  );

  modport slave (
    input  wen, waddr, wdata, wclr, raddr, issue_valid, issue_rd,
    output rdata, rbusy, any_busy, a0_value
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with per-register busy scoreboard.
// Highest write port wins on address conflicts; x0 is hardwired zero and never busy.
module regfile_mp_scoreboard #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NR_READ    = 2,
  parameter int unsigned NR_WRITE   = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  regfile_mp_scoreboard_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic [DEPTH-1:0]      w_set;
  logic [DEPTH-1:0]      w_clr;
  logic [DEPTH-1:0]      w_busy_nxt;

  // Ascending port order: the last non-blocking write of a conflict (highest port) lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rf <= '{default: '0};
    end else begin
      for (int unsigned k = 0; k < NR_WRITE; k++) begin
        if (bus.wen[k] && (bus.waddr[k*ADDR_WIDTH +: ADDR_WIDTH] != '0))
          r_rf[bus.waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (bus.issue_valid)
      w_set[bus.issue_rd] = 1'b1;
    for (int unsigned k = 0; k < NR_WRITE; k++) begin
      if (bus.wclr[k])
        w_clr[bus.waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
    end
    w_busy_nxt    = w_set | (r_busy & ~w_clr);
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  function automatic logic [DATA_WIDTH-1:0] rd_value(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    v = r_rf[a];
    if (BYPASS != 0) begin
      for (int unsigned k = 0; k < NR_WRITE; k++) begin
        if (bus.wen[k] && (bus.waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == a))
          v = bus.wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (a == '0)
      v = '0;
    return v;
  endfunction

  function automatic logic rd_busy(input logic [ADDR_WIDTH-1:0] a);
    logic b;
    b = r_busy[a];
    if (BYPASS != 0) begin
      for (int unsigned k = 0; k < NR_WRITE; k++) begin
        if (bus.wclr[k] && (bus.waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == a))
          b = 1'b0;
      end
    end
    if (a == '0)
      b = 1'b0;
    return b;
  endfunction

  // Outputs are forced to zero while reset is held, even if bypassed write data is present.
  for (genvar j = 0; j < NR_READ; j++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_raddr;
    assign w_raddr                            = bus.raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.rdata[j*DATA_WIDTH +: DATA_WIDTH] = reset ? rd_value(w_raddr) : '0;
    assign bus.rbusy[j]                       = reset & rd_busy(w_raddr);
  end

  assign bus.any_busy = reset & (|r_busy);

  if (DEPTH > 10) begin : g_a0
    assign bus.a0_value = reset ? r_rf[ADDR_WIDTH'(10)] : '0;
  end else begin : g_no_a0
    assign bus.a0_value = '0;
  end
endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: directed vector table, BYPASS=0 sequence, reset and random regress.
module tb_regfile_mp_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_scoreboard_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(4), .NR_WRITE(3)) bus ();
  regfile_mp_scoreboard_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2), .NR_WRITE(2)) bus_nb ();

  regfile_mp_scoreboard #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(4), .NR_WRITE(3), .BYPASS(1))
    u_dut (.clock(clk), .reset(rst_n), .bus(bus));
  regfile_mp_scoreboard #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2), .NR_WRITE(2), .BYPASS(0))
    u_nb (.clock(clk), .reset(rst_n), .bus(bus_nb));

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_rf [32];
  logic        m_busy [32];

  typedef struct {
    logic [2:0]       wen;
    logic [2:0][4:0]  waddr;
    logic [2:0][31:0] wdata;
    logic [2:0]       wclr;
    logic             iv;
    logic [4:0]       ird;
    logic [4:0]       ra;
    logic [31:0]      e_rd;
    logic             e_rb;
    logic             e_any;
    logic [31:0]      e_a0;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_rf[r]   = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    bus.wen = '0; bus.waddr = '0; bus.wdata = '0; bus.wclr = '0;
    bus.raddr = '0; bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus_nb.wen = '0; bus_nb.waddr = '0; bus_nb.wdata = '0; bus_nb.wclr = '0;
    bus_nb.raddr = '0; bus_nb.issue_valid = 1'b0; bus_nb.issue_rd = '0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    if (a == 0) return '0;
    v = m_rf[a];
    for (int k = 0; k < 3; k++)
      if (bus.wen[k] && bus.waddr[k*5 +: 5] == a) v = bus.wdata[k*32 +: 32];
    return v;
  endfunction

  function automatic logic exp_rb(input logic [4:0] a);
    logic b;
    if (a == 0) return 1'b0;
    b = m_busy[a];
    for (int k = 0; k < 3; k++)
      if (bus.wclr[k] && bus.waddr[k*5 +: 5] == a) b = 1'b0;
    return b;
  endfunction

  function automatic logic exp_any();
    logic o = 1'b0;
    for (int r = 0; r < 32; r++) o |= m_busy[r];
    return o;
  endfunction

  // Commits the current main-bus inputs into the model across one rising edge.
  task automatic tick();
    logic [31:0] nrf [32];
    logic        nbusy [32];
    for (int r = 0; r < 32; r++) begin
      nrf[r] = m_rf[r];
      nbusy[r] = m_busy[r];
    end
    for (int k = 0; k < 3; k++)
      if (bus.wen[k] && bus.waddr[k*5 +: 5] != 0) nrf[bus.waddr[k*5 +: 5]] = bus.wdata[k*32 +: 32];
    for (int k = 0; k < 3; k++)
      if (bus.wclr[k]) nbusy[bus.waddr[k*5 +: 5]] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != 0) nbusy[bus.issue_rd] = 1'b1;
    @(posedge clk);
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = nrf[r];
      m_busy[r] = nbusy[r];
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("%s.rdata%0d", tag, j), bus.rdata[j*32 +: 32], exp_rd(bus.raddr[j*5 +: 5]));
      chk($sformatf("%s.rbusy%0d", tag, j), 32'(bus.rbusy[j]), 32'(exp_rb(bus.raddr[j*5 +: 5])));
    end
    chk($sformatf("%s.any_busy", tag), 32'(bus.any_busy), 32'(exp_any()));
    chk($sformatf("%s.a0", tag), bus.a0_value, m_rf[10]);
  endtask

  initial begin
    tbl[0]  = '{3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'h5555, 32'hAAAA}, 3'b000, 1'b0, 5'd0, 5'd7, 32'h5555, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{3'b000, '0, '0, 3'b000, 1'b0, 5'd0, 5'd7, 32'h5555, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{3'b100, {5'd0, 5'd0, 5'd0}, {32'hFFFF_FFFF, 32'h0, 32'h0}, 3'b000, 1'b1, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{3'b000, '0, '0, 3'b000, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{3'b000, '0, '0, 3'b000, 1'b1, 5'd3, 5'd3, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{3'b000, {5'd0, 5'd3, 5'd0}, '0, 3'b010, 1'b1, 5'd3, 5'd3, 32'h0, 1'b0, 1'b1, 32'h0};
    tbl[6]  = '{3'b000, '0, '0, 3'b000, 1'b0, 5'd0, 5'd3, 32'h0, 1'b1, 1'b1, 32'h0};
    tbl[7]  = '{3'b000, {5'd0, 5'd0, 5'd3}, '0, 3'b001, 1'b0, 5'd0, 5'd3, 32'h0, 1'b0, 1'b1, 32'h0};
    tbl[8]  = '{3'b000, '0, '0, 3'b000, 1'b0, 5'd0, 5'd3, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{3'b001, {5'd0, 5'd0, 5'd10}, {32'h0, 32'h0, 32'h2A}, 3'b000, 1'b0, 5'd0, 5'd10, 32'h2A, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{3'b000, '0, '0, 3'b000, 1'b0, 5'd0, 5'd10, 32'h2A, 1'b0, 1'b0, 32'h2A};
    tbl[11] = '{3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h1234}, 3'b000, 1'b1, 5'd9, 5'd5, 32'h1234, 1'b0, 1'b0, 32'h2A};

    model_reset();
    idle_inputs();
    bus.raddr = {4{5'd7}};
    #12;
    chk("reset.rdata", bus.rdata[31:0], 32'h0);
    chk("reset.any_busy", 32'(bus.any_busy), 32'h0);
    chk("reset.a0", bus.a0_value, 32'h0);
    rst_n = 1'b1;
    #1;

    // BYPASS=0 instance: same-cycle reads see the stored value, no clear forwarding.
    bus_nb.wen = 2'b01; bus_nb.waddr = {5'd0, 5'd4}; bus_nb.wdata = {32'h0, 32'h77}; bus_nb.raddr = {5'd0, 5'd4};
    #1; chk("nb.first_write_old", bus_nb.rdata[31:0], 32'h0); tick();
    bus_nb.wdata = {32'h0, 32'h10};
    #1; chk("nb.same_cycle_old", bus_nb.rdata[31:0], 32'h77); tick();
    bus_nb.wen = '0; bus_nb.issue_valid = 1'b1; bus_nb.issue_rd = 5'd4;
    #1; chk("nb.next_cycle_new", bus_nb.rdata[31:0], 32'h10); tick();
    bus_nb.issue_valid = 1'b0; bus_nb.wclr = 2'b01;
    #1; chk("nb.clr_not_bypassed", 32'(bus_nb.rbusy[0]), 32'h1); tick();
    bus_nb.wclr = '0;
    #1; chk("nb.clr_done", 32'(bus_nb.rbusy[0]), 32'h0);
    chk("nb.any_busy", 32'(bus_nb.any_busy), 32'h0);

    for (int i = 0; i < 12; i++) begin
      bus.wen = tbl[i].wen; bus.waddr = tbl[i].waddr; bus.wdata = tbl[i].wdata;
      bus.wclr = tbl[i].wclr; bus.issue_valid = tbl[i].iv; bus.issue_rd = tbl[i].ird;
      bus.raddr = {4{tbl[i].ra}};
      #1;
      chk($sformatf("v%0d.rdata", i), bus.rdata[31:0], tbl[i].e_rd);
      chk($sformatf("v%0d.rbusy", i), 32'(bus.rbusy[0]), 32'(tbl[i].e_rb));
      chk($sformatf("v%0d.any_busy", i), 32'(bus.any_busy), 32'(tbl[i].e_any));
      chk($sformatf("v%0d.a0", i), bus.a0_value, tbl[i].e_a0);
      tick();
    end

    // Asynchronous reset mid-run with a bypassable write and an issue pending.
    bus.wen = 3'b001; bus.waddr = {5'd0, 5'd0, 5'd5}; bus.wdata = {32'h0, 32'h0, 32'h9999};
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd12; bus.raddr = {4{5'd5}};
    #1; chk("pre_reset.any_busy", 32'(bus.any_busy), 32'h1);
    #1; rst_n = 1'b0;
    #1;
    chk("async_reset.rdata", bus.rdata[31:0], 32'h0);
    chk("async_reset.rbusy", 32'(bus.rbusy[0]), 32'h0);
    chk("async_reset.any_busy", 32'(bus.any_busy), 32'h0);
    chk("async_reset.a0", bus.a0_value, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    idle_inputs();
    bus.raddr = {5'd10, 5'd9, 5'd7, 5'd5};
    #1; check_all("post_reset");

    for (int c = 0; c < 600; c++) begin
      bus.wen = 3'($urandom);
      bus.wclr = 3'($urandom) & 3'($urandom);
      for (int k = 0; k < 3; k++) begin
        bus.waddr[k*5 +: 5] = ($urandom % 2 != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        bus.wdata[k*32 +: 32] = $urandom;
      end
      for (int j = 0; j < 4; j++)
        bus.raddr[j*5 +: 5] = ($urandom % 2 != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(8, 31));
      bus.issue_valid = 1'($urandom);
      bus.issue_rd = 5'($urandom_range(0, 15));
      #1;
      check_all($sformatf("rnd%0d", c));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
